bus_switch_seq: RTL and testbench

BUS_SWITCH_SEQ -- requirements
Module: bus_switch_seq

---
 rtl/bus_switch_seq.sv | 128 ++++++++++++
 tb/tb_bus_switch_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_switch_seq.sv
// Two-requester bus switch sequencer: round-robin arbitration, timed switch
// drive, and a mandatory one-cycle dead phase between transfers.
module bus_switch_seq (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_valid,
    input  logic [3:0] req0_route,
    input  logic [3:0] req1_route,
    input  logic       req0_mask543,
    input  logic       req1_mask543,
    input  logic [2:0] req0_len,
    input  logic [2:0] req1_len,
    input  logic       abort,
    output logic       ctl_sw_1u,
    output logic       ctl_sw_1d,
    output logic       ctl_sw_2u,
    output logic       ctl_sw_2d,
    output logic       ctl_sw_mask543_en,
    output logic [1:0] gnt,
    output logic       err,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DEAD  = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic       ptr, ptr_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic [3:0] sw, sw_nxt;          // {2d,2u,1d,1u}
    logic       mask_en, mask_en_nxt;
    logic [1:0] gnt_nxt;
    logic       err_nxt;

    logic       win;
    logic [3:0] win_route;
    logic       win_mask;
    logic [2:0] win_len;
    logic       win_illegal;

    always_comb begin
        win         = req_valid[ptr] ? ptr : ~ptr;
        win_route   = win ? req1_route   : req0_route;
        win_mask    = win ? req1_mask543 : req0_mask543;
        win_len     = win ? req1_len     : req0_len;
        win_illegal = (win_route[0] & win_route[1]) |
                      (win_route[2] & win_route[3]) |
                      (win_route == 4'b0000);
    end

    // NOTE: every signal gets its default before the case so no path leaves
    // one unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        cnt_nxt     = cnt;
        sw_nxt      = sw;
        mask_en_nxt = mask_en;
        gnt_nxt     = 2'b00;
        err_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    ptr_nxt      = ~win;
                    gnt_nxt[win] = 1'b1;
                    if (win_illegal) begin
                        err_nxt   = 1'b1;
                        state_nxt = DEAD;
                    end else begin
                        state_nxt   = DRIVE;
                        sw_nxt      = win_route;
                        mask_en_nxt = win_mask & win_route[1];
                        cnt_nxt     = win_len;
                    end
                end
            end
            DRIVE: begin
                if (cnt == 3'd0 || abort) begin
                    state_nxt   = DEAD;
                    sw_nxt      = 4'b0000;
                    mask_en_nxt = 1'b0;
                    cnt_nxt     = 3'd0;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            DEAD: state_nxt = IDLE;
            default: begin
                state_nxt   = IDLE;
                sw_nxt      = 4'b0000;
                mask_en_nxt = 1'b0;
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values; the async reset drops the switches without a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= 1'b0;
            cnt     <= 3'd0;
            sw      <= 4'b0000;
            mask_en <= 1'b0;
            gnt     <= 2'b00;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            cnt     <= cnt_nxt;
            sw      <= sw_nxt;
            mask_en <= mask_en_nxt;
            gnt     <= gnt_nxt;
            err     <= err_nxt;
        end
    end

    assign ctl_sw_1u         = sw[0];
    assign ctl_sw_1d         = sw[1];
    assign ctl_sw_2u         = sw[2];
    assign ctl_sw_2d         = sw[3];
    assign ctl_sw_mask543_en = mask_en;
    assign busy              = (state != IDLE);

endmodule

// File: tb/tb_bus_switch_seq.sv
// Bench for bus_switch_seq: a cycle-indexed schedule model of expected outputs,
// a per-cycle compare process, and literal checks on recorded history.
module tb_bus_switch_seq;

    localparam int N = 512;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] req_valid = 2'b00;
    logic [3:0] req0_route = 4'b0, req1_route = 4'b0;
    logic       req0_mask543 = 1'b0, req1_mask543 = 1'b0;
    logic [2:0] req0_len = 3'd0, req1_len = 3'd0;
    logic       abort = 1'b0;
    logic       ctl_sw_1u, ctl_sw_1d, ctl_sw_2u, ctl_sw_2d, ctl_sw_mask543_en;
    logic [1:0] gnt;
    logic       err, busy;

    bus_switch_seq dut (
        .clk(clk), .reset(reset), .req_valid(req_valid),
        .req0_route(req0_route), .req1_route(req1_route),
        .req0_mask543(req0_mask543), .req1_mask543(req1_mask543),
        .req0_len(req0_len), .req1_len(req1_len), .abort(abort),
        .ctl_sw_1u(ctl_sw_1u), .ctl_sw_1d(ctl_sw_1d),
        .ctl_sw_2u(ctl_sw_2u), .ctl_sw_2d(ctl_sw_2d),
        .ctl_sw_mask543_en(ctl_sw_mask543_en), .gnt(gnt), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected outputs per cycle; cycle k is the interval after the k-th edge since reset.
    int         cyc;
    int         free_edge, drv_start, drv_last;
    bit         drv_on, p;
    logic [3:0] e_sw[N];
    logic [1:0] e_gnt[N];
    bit         e_mask[N], e_err[N], e_busy[N];
    logic [3:0] h_sw[N];
    logic [1:0] h_gnt[N];
    bit         h_mask[N], h_err[N], h_busy[N];

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            e_sw[i] = 4'b0; e_gnt[i] = 2'b0; e_mask[i] = 0; e_err[i] = 0; e_busy[i] = 0;
        end
        cyc = 0; free_edge = 1; drv_on = 0; p = 0; drv_start = 0; drv_last = 0;
    endtask

    task automatic model_edge();
        bit         w, m, illegal;
        logic [3:0] r;
        int         l;
        cyc++;
        if (drv_on && abort && cyc > drv_start && cyc <= drv_last) begin
            for (int c = cyc; c <= drv_last + 1 && c < N; c++) begin
                e_sw[c] = 4'b0; e_mask[c] = 0; e_busy[c] = 0;
            end
            e_busy[cyc] = 1;
            free_edge = cyc + 2;
            drv_on = 0;
        end
        if (drv_on && cyc > drv_last) drv_on = 0;
        if (cyc >= free_edge && req_valid != 2'b00) begin
            w = req_valid[p] ? p : !p;
            r = w ? req1_route : req0_route;
            m = w ? req1_mask543 : req0_mask543;
            l = w ? int'(req1_len) : int'(req0_len);
            p = !w;
            illegal = (r[0] && r[1]) || (r[2] && r[3]) || (r == 4'b0);
            e_gnt[cyc][w] = 1'b1;
            if (illegal) begin
                e_err[cyc] = 1; e_busy[cyc] = 1;
                free_edge = cyc + 2;
            end else begin
                for (int k = 0; k <= l && cyc + k < N; k++) begin
                    e_sw[cyc + k] = r; e_mask[cyc + k] = m && r[1]; e_busy[cyc + k] = 1;
                end
                if (cyc + l + 1 < N) e_busy[cyc + l + 1] = 1;
                drv_start = cyc; drv_last = cyc + l; drv_on = 1;
                free_edge = cyc + l + 3;
            end
        end
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_clear();
            else model_edge();
        end
    end

    // Compare process: every cycle outside reset.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && cyc < N) begin
                h_sw[cyc]   = {ctl_sw_2d, ctl_sw_2u, ctl_sw_1d, ctl_sw_1u};
                h_mask[cyc] = ctl_sw_mask543_en;
                h_gnt[cyc]  = gnt;
                h_err[cyc]  = err;
                h_busy[cyc] = busy;
                check($sformatf("cycle%0d outputs", cyc),
                      {7'b0, ctl_sw_2d, ctl_sw_2u, ctl_sw_1d, ctl_sw_1u, ctl_sw_mask543_en, gnt, err, busy},
                      {7'b0, e_sw[cyc], e_mask[cyc], e_gnt[cyc], e_err[cyc], e_busy[cyc]});
            end
        end
    end

    function automatic int count_sw(input int bitn, input int from, input int to);
        int n = 0;
        for (int c = from; c <= to && c < N; c++) if (h_sw[c][bitn]) n++;
        return n;
    endfunction

    function automatic int count_mask(input int from, input int to);
        int n = 0;
        for (int c = from; c <= to && c < N; c++) if (h_mask[c]) n++;
        return n;
    endfunction

    task automatic do_req(input int idx, input logic [3:0] r, input logic m, input logic [2:0] l,
                          output int g);
        bit seen = 0;
        if (idx == 0) begin req0_route = r; req0_mask543 = m; req0_len = l; end
        else          begin req1_route = r; req1_mask543 = m; req1_len = l; end
        req_valid[idx] = 1'b1;
        g = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (gnt[idx]) begin seen = 1; g = cyc; break; end
        end
        check("grant_timeout", 16'(seen), 16'd1);
        req_valid[idx] = 1'b0;
    endtask

    task automatic wait_idle();
        bit idle = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) begin idle = 1; break; end
        end
        check("idle_timeout", 16'(idle), 16'd1);
        @(negedge clk);
    endtask

    initial begin
        int g;
        int ord[4];
        int gc[4];
        int n;

        #1;
        check("reset_state", {7'b0, ctl_sw_2d, ctl_sw_2u, ctl_sw_1d, ctl_sw_1u, ctl_sw_mask543_en, gnt, err, busy}, 16'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 1u for len+1 = 3 cycles, one dead cycle, then idle
        do_req(0, 4'b0001, 1'b0, 3'd2, g);
        wait_idle();
        check("s1_gnt", 16'(h_gnt[g]), 16'b01);
        check("s1_gnt_once", 16'(h_gnt[g + 1]), 16'b00);
        check("s1_1u_cycles", 16'(count_sw(0, g - 1, g + 5)), 16'd3);
        check("s1_dead", {11'b0, h_sw[g + 3], h_busy[g + 3]}, 16'b00001);
        check("s1_idle", 16'(h_busy[g + 4]), 16'd0);

        // illegal route: grant + error together, no switching
        do_req(1, 4'b0011, 1'b0, 3'd3, g);
        wait_idle();
        check("s2_gnt_err", {13'b0, h_gnt[g], h_err[g]}, 16'b101);
        check("s2_no_sw", 16'(count_sw(0, g, g + 2) + count_sw(1, g, g + 2)), 16'd0);
        check("s2_idle_after", 16'(h_busy[g + 1]), 16'd0);

        // abort during the second drive cycle of a len=4 transfer
        do_req(0, 4'b0010, 1'b1, 3'd4, g);
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        wait_idle();
        check("s3_1d_cycles", 16'(count_sw(1, g, g + 6)), 16'd2);
        check("s3_mask_cycles", 16'(count_mask(g, g + 6)), 16'd2);

        // abort during the first drive cycle still drives that cycle
        do_req(1, 4'b0001, 1'b0, 3'd3, g);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        wait_idle();
        check("s4_gnt", 16'(h_gnt[g]), 16'b10);
        check("s4_1u_cycles", 16'(count_sw(0, g, g + 5)), 16'd1);

        // abort seen only while idle is ignored
        abort = 1'b1;
        do_req(0, 4'b0100, 1'b0, 3'd2, g);
        abort = 1'b0;
        wait_idle();
        check("s5_2u_cycles", 16'(count_sw(2, g, g + 5)), 16'd3);

        // mask ignored unless route selects 1d
        do_req(1, 4'b1000, 1'b1, 3'd1, g);
        wait_idle();
        check("s6_2d_cycles", 16'(count_sw(3, g, g + 4)), 16'd2);
        check("s6_mask_cycles", 16'(count_mask(g, g + 4)), 16'd0);

        // maximum length drives 8 cycles
        do_req(0, 4'b0100, 1'b0, 3'd7, g);
        wait_idle();
        check("s7_2u_cycles", 16'(count_sw(2, g, g + 10)), 16'd8);

        // reset mid-drive drops outputs without a clock edge
        do_req(0, 4'b0101, 1'b0, 3'd7, g);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("s8_async_drop", {9'b0, ctl_sw_2d, ctl_sw_2u, ctl_sw_1d, ctl_sw_1u, ctl_sw_mask543_en, busy}, 16'd0);
        @(negedge clk);
        reset = 1'b0;

        // both held: alternating grants starting at requester 0 on the first edge
        req0_route = 4'b0001; req0_len = 3'd0; req0_mask543 = 1'b0;
        req1_route = 4'b0100; req1_len = 3'd1; req1_mask543 = 1'b0;
        req_valid = 2'b11;
        n = 0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            @(negedge clk);
            if (gnt != 2'b00) begin
                ord[n] = gnt[1] ? 1 : 0;
                gc[n] = cyc;
                n++;
            end
        end
        req_valid = 2'b00;
        check("s9_grant_count", 16'(n), 16'd4);
        if (n == 4) begin
            check("s9_order", {12'b0, 1'(ord[0]), 1'(ord[1]), 1'(ord[2]), 1'(ord[3])}, 16'b0101);
            check("s9_first_edge", 16'(gc[0]), 16'd1);
            check("s9_gap01", 16'(gc[1] - gc[0]), 16'd3);
            check("s9_gap12", 16'(gc[2] - gc[1]), 16'd4);
            check("s9_gap23", 16'(gc[3] - gc[2]), 16'd3);
        end
        wait_idle();
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
